// File: rtl/jpeg_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : jpeg_pkg
// Brief   : Shared types and sizes for the JPEG transpose stage.
// Revision: 1.0  initial release
// ----------------------------------------------------------------------------
package jpeg_pkg;

  // Transpose controller phase: filling rows or draining columns.
  typedef enum logic {S_FILL, S_DRAIN} tp_state_t;

  localparam int TP_ROWS   = 8;
  localparam int TP_COLS   = 8;
  localparam int TP_ELEM_W = 12;

endpackage : jpeg_pkg
`default_nettype wire

// File: rtl/tp_mod_cnt.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : tp_mod_cnt
// Brief   : Modulo-N up counter with clear, increment and last-value flag.
// Revision: 1.0  initial release
// ----------------------------------------------------------------------------
module tp_mod_cnt #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  // Terminal value compared explicitly so N need not be a power of two.
  localparam logic [W-1:0] c_last = W'(N - 1);

  logic [W-1:0] r_cnt;

  // Count register: clear wins over increment, increment wraps at N-1.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (inc) begin
      r_cnt <= (r_cnt == c_last) ? '0 : r_cnt + W'(1);
    end
  end

  assign cnt  = r_cnt;
  assign wrap = (r_cnt == c_last);

endmodule : tp_mod_cnt
`default_nettype wire

// File: rtl/transpose_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : transpose_ctrl
// Brief   : Single-buffered fill/drain sequencer for the 8x8 transpose memory.
// Revision: 1.0  initial release
// ----------------------------------------------------------------------------
module transpose_ctrl
  import jpeg_pkg::*;
#(
  parameter int ROWS  = TP_ROWS,
  parameter int COLS  = TP_COLS,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             wr,
  output logic             rd,
  output logic [IDX_W-1:0] row_idx,
  output logic [IDX_W-1:0] col_idx,
  output logic             block_done
);

  tp_state_t r_state;
  tp_state_t w_state_nxt;
  logic      w_row_wrap;
  logic      w_col_wrap;

  // Row counter: advances on every accepted row write.
  tp_mod_cnt #(.N(ROWS), .W(IDX_W)) u_row_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (flush),
    .inc  (wr),
    .cnt  (row_idx),
    .wrap (w_row_wrap)
  );

  // Column counter: advances on every consumed column.
  tp_mod_cnt #(.N(COLS), .W(IDX_W)) u_col_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (flush),
    .inc  (rd),
    .cnt  (col_idx),
    .wrap (w_col_wrap)
  );

  // Phase register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Strobe decode and next phase; flush suppresses every handshake so a
  // partially written or partially read block is never exposed.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    wr          = 1'b0;
    rd          = 1'b0;
    block_done  = 1'b0;
    unique case (r_state)
      S_FILL: begin
        in_ready = !flush;
        wr       = in_valid && !flush;
        if (wr && w_row_wrap) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        out_valid  = !flush;
        rd         = out_ready && !flush;
        block_done = rd && w_col_wrap;
        if (block_done) begin
          w_state_nxt = S_FILL;
        end
      end
      default: w_state_nxt = S_FILL;
    endcase
    if (flush) begin
      w_state_nxt = S_FILL;
    end
  end

endmodule : transpose_ctrl
`default_nettype wire

// File: tb/tb_transpose_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : tb_transpose_ctrl
// Brief   : Self-checking bench for transpose_ctrl with a behavioural model
//           and a transpose memory driven by the controller strobes.
// Revision: 1.0  initial release
// ----------------------------------------------------------------------------
module tb_transpose_ctrl;

  logic       clk = 1'b0;
  logic       rst, flush, in_valid, out_ready;
  logic       in_ready, out_valid, wr, rd, block_done;
  logic [2:0] row_idx, col_idx;
  logic [95:0] in_data;

  int n_checks = 0;
  int n_pass   = 0;

  transpose_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .wr         (wr),
    .rd         (rd),
    .row_idx    (row_idx),
    .col_idx    (col_idx),
    .block_done (block_done)
  );

  always #5 clk = ~clk;

  // Transpose memory as the real block would see it: rows land where the
  // controller says, columns are read out at the controller's column index.
  logic [95:0] tb_mem [8];
  always @(posedge clk) begin
    if (wr) tb_mem[row_idx] <= in_data;
  end

  function automatic logic [95:0] col_bus();
    logic [95:0] b;
    for (int r = 0; r < 8; r++) b[r*12 +: 12] = tb_mem[r][col_idx*12 +: 12];
    return b;
  endfunction

  // Reference model: a block is 8 accepted rows followed by 8 consumed columns.
  bit          m_drain;
  int          m_wrs, m_rds;
  logic [95:0] m_rows [8];

  function automatic logic [95:0] exp_col();
    logic [95:0] b;
    for (int r = 0; r < 8; r++) b[r*12 +: 12] = m_rows[r][m_rds*12 +: 12];
    return b;
  endfunction

  // {in_ready, out_valid, wr, rd, block_done, row_idx, col_idx}
  function automatic logic [10:0] exp_vec();
    logic e_wr, e_rd;
    e_wr = !m_drain && in_valid && !flush;
    e_rd = m_drain && out_ready && !flush;
    return {!m_drain && !flush, m_drain && !flush, e_wr, e_rd,
            e_rd && (m_rds == 7), 3'(m_wrs), 3'(m_rds)};
  endfunction

  function automatic logic [10:0] obs_vec();
    return {in_ready, out_valid, wr, rd, block_done, row_idx, col_idx};
  endfunction

  function automatic void model_update();
    if (rst || flush) begin
      m_drain = 0; m_wrs = 0; m_rds = 0;
    end else if (!m_drain && in_valid) begin
      m_rows[m_wrs] = in_data;
      m_wrs++;
      if (m_wrs == 8) begin m_wrs = 0; m_drain = 1; end
    end else if (m_drain && out_ready) begin
      m_rds++;
      if (m_rds == 8) begin m_rds = 0; m_drain = 0; end
    end
  endfunction

  // Drive inputs just after the edge; outputs are sampled on the falling edge.
  task automatic drive(input logic iv, input logic ordy, input logic fl);
    in_valid  = iv;
    out_ready = ordy;
    flush     = fl;
    in_data   = {$urandom, $urandom, $urandom};
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  always @(posedge clk) begin
    assert (!(wr && rd)) else $error("FAIL wr_rd_overlap wr=%b rd=%b", wr, rd);
  end

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b0, 1'b0); tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (obs_vec() !== 11'b100_00_000_000)
      $display("FAIL reset_state got=%b exp=%b", obs_vec(), 11'b100_00_000_000);
    else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back();
    for (int c = 1; c <= 17; c++) begin
      drive(c <= 8, 1'b1, 1'b0);
      n_checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL b2b_vec cyc=%0d got=%b exp=%b", c, obs_vec(), exp_vec());
      else n_pass++;
      n_checks++;
      if ({wr, out_valid, rd, block_done, in_ready} !==
          {c <= 8, c >= 9 && c <= 16, c >= 9 && c <= 16, c == 16, c <= 8 || c == 17})
        $display("FAIL b2b_timing cyc=%0d got wr/ov/rd/bd/ir=%b%b%b%b%b", c, wr, out_valid, rd, block_done, in_ready);
      else n_pass++;
      if (c >= 9 && c <= 16) begin
        n_checks++;
        if (col_idx !== 3'(c - 9) || col_bus() !== exp_col())
          $display("FAIL b2b_column cyc=%0d col=%0d bus=%h exp=%h", c, col_idx, col_bus(), exp_col());
        else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_gapped();
    int first_ov = 0;
    for (int c = 1; c <= 24; c++) begin
      drive(c[0], 1'b1, 1'b0);
      n_checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL gap_vec cyc=%0d got=%b exp=%b", c, obs_vec(), exp_vec());
      else n_pass++;
      if (out_valid && first_ov == 0) first_ov = c;
      tick();
    end
    n_checks++;
    if (first_ov !== 16) $display("FAIL gap_drain_entry got=%0d exp=16", first_ov);
    else n_pass++;
  endtask

  task automatic test_stall();
    logic [95:0] held;
    for (int c = 0; c < 8; c++) begin drive(1'b1, 1'b0, 1'b0); tick(); end
    for (int c = 0; c < 3; c++) begin drive(1'b0, 1'b1, 1'b0); tick(); end
    drive(1'b0, 1'b0, 1'b0);
    held = col_bus();
    for (int c = 0; c < 5; c++) begin
      if (c > 0) drive(1'b0, 1'b0, 1'b0);
      n_checks++;
      if (rd !== 1'b0 || col_idx !== 3'd3 || out_valid !== 1'b1 || col_bus() !== held || held !== exp_col())
        $display("FAIL stall_hold cyc=%0d rd=%b col=%0d ov=%b bus=%h exp=%h", c, rd, col_idx, out_valid, col_bus(), exp_col());
      else n_pass++;
      tick();
    end
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, 1'b1, 1'b0);
      n_checks++;
      if (obs_vec() !== exp_vec() || col_bus() !== exp_col())
        $display("FAIL stall_resume cyc=%0d got=%b exp=%b", c, obs_vec(), exp_vec());
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_input_while_draining();
    for (int c = 0; c < 40; c++) begin
      drive(1'b1, 1'($urandom_range(0, 1)), 1'b0);
      n_checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL drain_in_vec cyc=%0d got=%b exp=%b", c, obs_vec(), exp_vec());
      else n_pass++;
      if (m_drain) begin
        n_checks++;
        if (in_ready !== 1'b0 || wr !== 1'b0) $display("FAIL drain_in_ignored cyc=%0d ir=%b wr=%b", c, in_ready, wr);
        else n_pass++;
      end
      tick();
    end
    while (m_drain) begin drive(1'b0, 1'b1, 1'b0); tick(); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0));
      n_checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL rand_vec cyc=%0d got=%b exp=%b", c, obs_vec(), exp_vec());
      else n_pass++;
      if (out_valid) begin
        n_checks++;
        if (col_bus() !== exp_col()) $display("FAIL rand_column cyc=%0d bus=%h exp=%h", c, col_bus(), exp_col());
        else n_pass++;
      end
      tick();
    end
    drive(1'b0, 1'b0, 1'b1); tick();
  endtask

  task automatic test_abort();
    int wcount = 0;
    int guard  = 0;
    for (int c = 0; c < 8; c++) begin drive(1'b1, 1'b0, 1'b0); tick(); end
    for (int c = 0; c < 4; c++) begin drive(1'b0, 1'b1, 1'b0); tick(); end
    drive(1'b0, 1'b1, 1'b1);
    n_checks++;
    if (col_idx !== 3'd4 || rd !== 1'b0 || block_done !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL flush_cycle col=%0d rd=%b bd=%b ov=%b", col_idx, rd, block_done, out_valid);
    else n_pass++;
    tick();
    drive(1'b0, 1'b1, 1'b0);
    n_checks++;
    if (obs_vec() !== 11'b100_00_000_000) $display("FAIL flush_after got=%b exp=%b", obs_vec(), 11'b100_00_000_000);
    else n_pass++;
    tick();
    for (int c = 0; c < 5; c++) begin drive(1'b1, 1'b1, 1'b0); tick(); end
    drive(1'b0, 1'b1, 1'b0);
    n_checks++;
    if (row_idx !== 3'd5) $display("FAIL pre_rst_row got=%0d exp=5", row_idx);
    else n_pass++;
    rst = 1'b1; tick(); rst = 1'b0;
    drive(1'b0, 1'b1, 1'b0);
    n_checks++;
    if (obs_vec() !== 11'b100_00_000_000) $display("FAIL rst_after got=%b exp=%b", obs_vec(), 11'b100_00_000_000);
    else n_pass++;
    tick();
    while (!out_valid && guard < 100) begin
      drive(1'($urandom_range(0, 1)), 1'b1, 1'b0);
      if (out_valid) break;
      if (wr) wcount++;
      tick();
      guard++;
    end
    n_checks++;
    if (!out_valid || wcount !== 8) $display("FAIL abort_refill ov=%b writes=%0d exp=8", out_valid, wcount);
    else n_pass++;
    tick();
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    m_drain = 0; m_wrs = 0; m_rds = 0;
    #1;
    test_reset();
    test_back_to_back();
    test_gapped();
    test_stall();
    test_input_while_draining();
    test_random();
    test_abort();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_transpose_ctrl
`default_nettype wire
